// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war playfield.
// Winner codes match the two-bit indicator field seen by the display stage.
package tow_pkg;

   typedef enum logic [1:0] {
      PLAY  = 2'd0,
      WIN_L = 2'd1,
      WIN_R = 2'd2,
      OVER  = 2'd3
   } state_t;

   localparam logic [1:0] WIN_NONE  = 2'b00;
   localparam logic [1:0] WIN_LEFT  = 2'b01;
   localparam logic [1:0] WIN_RIGHT = 2'b10;

   localparam int unsigned SCORE_W = 3;

endpackage

// File: rtl/tow_score.sv
// Per-player score: saturating up-counter that stops at SCORE_MAX.
module tow_score
   import tow_pkg::*;
#(
   parameter int unsigned SCORE_MAX = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_inc,
   output logic [SCORE_W-1:0] o_score
);

   localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);

   logic [SCORE_W-1:0] r_score;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_score <= '0;
      end else if (i_inc && (r_score != SCORE_TOP)) begin
         r_score <= r_score + SCORE_W'(1);
      end
   end

   assign o_score = r_score;

endmodule

// File: rtl/tow_field.sv
// Tug-of-war playfield: moves one lit position on press pulses, detects
// round wins off either edge, holds the win display, then restarts or ends.
module tow_field
   import tow_pkg::*;
#(
   parameter int unsigned N_LIGHTS    = 9,
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned SCORE_MAX   = 7
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                l_press,
   input  logic                r_press,
   output logic [N_LIGHTS-1:0] leds,
   output logic [1:0]          winner,
   output logic [SCORE_W-1:0]  score_l,
   output logic [SCORE_W-1:0]  score_r,
   output logic                game_over
);

   localparam int unsigned POS_W  = $clog2(N_LIGHTS);
   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [POS_W-1:0]   POS_CENTRE = POS_W'(N_LIGHTS / 2);
   localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(N_LIGHTS - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [SCORE_W-1:0] SCORE_TOP  = SCORE_W'(SCORE_MAX);

   state_t              r_state,     w_state_nx;
   logic [POS_W-1:0]    r_pos,       w_pos_nx;
   logic [HOLD_W-1:0]   r_hold,      w_hold_nx;
   logic [1:0]          r_winner,    w_winner_nx;
   logic                r_game_over, w_game_over_nx;
   logic                w_inc_l, w_inc_r;
   logic                w_mv_l, w_mv_r;
   logic                w_winner_max;
   logic [N_LIGHTS-1:0] w_leds;

   // Simultaneous presses cancel, so only an exclusive press moves the light.
   assign w_mv_l = l_press & ~r_press;
   assign w_mv_r = r_press & ~l_press;

   // Scores are already updated on the win edge, so the hold can read them.
   assign w_winner_max = (r_state == WIN_L) ? (score_l == SCORE_TOP)
                                            : (score_r == SCORE_TOP);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= PLAY;
         r_pos       <= POS_CENTRE;
         r_hold      <= '0;
         r_winner    <= WIN_NONE;
         r_game_over <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_pos       <= w_pos_nx;
         r_hold      <= w_hold_nx;
         r_winner    <= w_winner_nx;
         r_game_over <= w_game_over_nx;
      end
   end

   always_comb begin
      w_state_nx     = r_state;
      w_pos_nx       = r_pos;
      w_hold_nx      = r_hold;
      w_winner_nx    = r_winner;
      w_game_over_nx = r_game_over;
      w_inc_l        = 1'b0;
      w_inc_r        = 1'b0;
      case (r_state)
         PLAY: begin
            if (w_mv_l) begin
               if (r_pos == POS_LAST) begin
                  w_state_nx  = WIN_L;
                  w_winner_nx = WIN_LEFT;
                  w_inc_l     = 1'b1;
                  w_hold_nx   = '0;
               end else begin
                  w_pos_nx = r_pos + POS_W'(1);
               end
            end else if (w_mv_r) begin
               if (r_pos == '0) begin
                  w_state_nx  = WIN_R;
                  w_winner_nx = WIN_RIGHT;
                  w_inc_r     = 1'b1;
                  w_hold_nx   = '0;
               end else begin
                  w_pos_nx = r_pos - POS_W'(1);
               end
            end
         end
         WIN_L, WIN_R: begin
            if (r_hold == HOLD_LAST) begin
               w_hold_nx = '0;
               if (w_winner_max) begin
                  w_state_nx     = OVER;
                  w_game_over_nx = 1'b1;
               end else begin
                  w_state_nx  = PLAY;
                  w_pos_nx    = POS_CENTRE;
                  w_winner_nx = WIN_NONE;
               end
            end else begin
               w_hold_nx = r_hold + HOLD_W'(1);
            end
         end
         OVER: begin
         end
      endcase
   end

   always_comb begin
      w_leds = '0;
      if (r_state == PLAY) begin
         w_leds[r_pos] = 1'b1;
      end
   end

   tow_score #(.SCORE_MAX(SCORE_MAX)) u_score_l (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_inc_l),
      .o_score (score_l)
   );

   tow_score #(.SCORE_MAX(SCORE_MAX)) u_score_r (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_inc_r),
      .o_score (score_r)
   );

   assign leds      = w_leds;
   assign winner    = r_winner;
   assign game_over = r_game_over;

endmodule

// File: tb/tb_tow_field.sv
// Bench for tow_field: a default instance and a SCORE_MAX=2 instance share
// stimulus; each is compared every cycle against a cycle-level game model.
module tb_tow_field;

   localparam int N    = 9;
   localparam int HOLD = 4;

   logic clk     = 1'b0;
   logic reset   = 1'b1;
   logic l_press = 1'b0;
   logic r_press = 1'b0;

   logic [N-1:0] leds0, leds1;
   logic [1:0]   win0, win1;
   logic [2:0]   sl0, sr0, sl1, sr1;
   logic         go0, go1;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Game model state per instance: mode 0 play, 1 left won, 2 right won, 3 over
   int m_pos[2], m_mode[2], m_shown[2], m_sl[2], m_sr[2];
   int smax[2] = '{7, 2};

   bit seen_hold_reset = 1'b0;
   bit seen_over       = 1'b0;

   always #5 clk = ~clk;

   tow_field u_dut0 (
      .clk       (clk),
      .reset     (reset),
      .l_press   (l_press),
      .r_press   (r_press),
      .leds      (leds0),
      .winner    (win0),
      .score_l   (sl0),
      .score_r   (sr0),
      .game_over (go0)
   );

   tow_field #(.N_LIGHTS(9), .HOLD_CYCLES(4), .SCORE_MAX(2)) u_dut1 (
      .clk       (clk),
      .reset     (reset),
      .l_press   (l_press),
      .r_press   (r_press),
      .leds      (leds1),
      .winner    (win1),
      .score_l   (sl1),
      .score_r   (sr1),
      .game_over (go1)
   );

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pos[k]   = N / 2;
         m_mode[k]  = 0;
         m_shown[k] = 0;
         m_sl[k]    = 0;
         m_sr[k]    = 0;
      end
   endtask

   task automatic model_step(input int k, input bit l, input bit r);
      case (m_mode[k])
         0: begin
            if (l && !r) begin
               if (m_pos[k] == N - 1) begin
                  m_mode[k] = 1; m_shown[k] = 1;
                  if (m_sl[k] < smax[k]) m_sl[k] += 1;
               end else m_pos[k] += 1;
            end else if (r && !l) begin
               if (m_pos[k] == 0) begin
                  m_mode[k] = 2; m_shown[k] = 1;
                  if (m_sr[k] < smax[k]) m_sr[k] += 1;
               end else m_pos[k] -= 1;
            end
         end
         1, 2: begin
            if (m_shown[k] == HOLD) begin
               if (((m_mode[k] == 1) ? m_sl[k] : m_sr[k]) == smax[k]) m_mode[k] = 3;
               else begin
                  m_mode[k] = 0;
                  m_pos[k]  = N / 2;
               end
            end else m_shown[k] += 1;
         end
         default: ;
      endcase
   endtask

   function automatic int exp_winner(input int k);
      if (m_mode[k] == 1) return 1;
      if (m_mode[k] == 2) return 2;
      if (m_mode[k] == 3) return (m_sl[k] == smax[k]) ? 1 : 2;
      return 0;
   endfunction

   task automatic compare_all(input string ph);
      int exp_leds;
      for (int k = 0; k < 2; k++) begin
         exp_leds = (m_mode[k] == 0) ? (1 << m_pos[k]) : 0;
         if (k == 0) begin
            check({ph, "_leds0"}, 32'(leds0), exp_leds);
            check({ph, "_win0"},  32'(win0),  exp_winner(0));
            check({ph, "_sl0"},   32'(sl0),   m_sl[0]);
            check({ph, "_sr0"},   32'(sr0),   m_sr[0]);
            check({ph, "_go0"},   32'(go0),   (m_mode[0] == 3) ? 1 : 0);
         end else begin
            check({ph, "_leds1"}, 32'(leds1), exp_leds);
            check({ph, "_win1"},  32'(win1),  exp_winner(1));
            check({ph, "_sl1"},   32'(sl1),   m_sl[1]);
            check({ph, "_sr1"},   32'(sr1),   m_sr[1]);
            check({ph, "_go1"},   32'(go1),   (m_mode[1] == 3) ? 1 : 0);
         end
      end
   endtask

   task automatic drive_cycle(input bit l, input bit r, input string ph);
      @(negedge clk);
      l_press = l;
      r_press = r;
      @(posedge clk);
      model_step(0, l, r);
      model_step(1, l, r);
      #1;
      compare_all(ph);
   endtask

   // Reset dropped 3 time units after an edge, well clear of either edge.
   task automatic async_reset();
      @(posedge clk);
      #3;
      l_press = 1'b0;
      r_press = 1'b0;
      reset   = 1'b0;
      #1;
      model_reset();
      compare_all("rst");
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      bit l, r;
      int pl, pr;
      #1 reset = 1'b0;
      #1;
      model_reset();
      compare_all("por");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      repeat (5) drive_cycle(1'b0, 1'b0, "idle");
      repeat (3) drive_cycle(1'b1, 1'b0, "step");
      drive_cycle(1'b1, 1'b1, "both_mid");
      drive_cycle(1'b1, 1'b0, "step");
      drive_cycle(1'b1, 1'b1, "both_edge");
      drive_cycle(1'b1, 1'b0, "win_l");
      drive_cycle(1'b0, 1'b1, "hold_r");
      repeat (6) drive_cycle(1'b0, 1'b0, "hold");

      for (int i = 0; i < 4000; i++) begin
         case ((i / 200) % 3)
            0:       begin pl = 40; pr = 8;  end
            1:       begin pl = 8;  pr = 40; end
            default: begin pl = 45; pr = 45; end
         endcase
         l = ($urandom_range(0, 99) < pl);
         r = ($urandom_range(0, 99) < pr);
         drive_cycle(l, r, "rnd");
         if (m_mode[1] == 3) seen_over = 1'b1;
         if (!seen_hold_reset && m_mode[0] == 2 && i > 1500) begin
            seen_hold_reset = 1'b1;
            async_reset();
         end else if ($urandom_range(0, 999) == 0) begin
            async_reset();
         end
      end

      check("hold_reset_seen", 32'(seen_hold_reset), 1);
      check("over_seen", 32'(seen_over), 1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
